// File: rtl/fp16_pkg.sv
// fp16_pkg: shared IEEE-754 half-precision constants and converter state encoding
//   EXP_BIAS, SIGN_W/EXP_W/MANT_W field widths, HALF_ZERO, i2f_state_t
package fp16_pkg;

    localparam int EXP_BIAS = 15;
    localparam int SIGN_W   = 1;
    localparam int EXP_W    = 5;
    localparam int MANT_W   = 10;

    localparam logic [SIGN_W+EXP_W+MANT_W-1:0] HALF_ZERO = 16'h0000;

    typedef enum logic [2:0] {
        IDLE,
        RD_HI,
        RD_LO,
        NORM,
        ROUND,
        WR_HI,
        WR_LO,
        DONE
    } i2f_state_t;

endpackage

// File: rtl/fp16_round_rne.sv
// fp16_round_rne: packs a left-normalized 16-bit magnitude into a half float (round-to-nearest-even)
//   mag    : magnitude shifted so mag[15] is the leading one (or all zero)
//   s      : number of left shifts applied during normalization
//   sign   : sign bit of the original integer
//   result : packed {sign, exp, mant}
import fp16_pkg::*;

module fp16_round_rne (
    input  logic [15:0] mag,
    input  logic [3:0]  s,
    input  logic        sign,
    output logic [15:0] result
);

    // Leading one at bit 15 with no shifts means value 2^15.
    localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(EXP_BIAS + 15);

    logic [MANT_W-1:0] mant;
    logic              guard;
    logic              sticky;
    logic              inc;
    logic [MANT_W:0]   sum;
    logic [EXP_W-1:0]  exp;

    always_comb begin
        mant   = mag[14:5];
        guard  = mag[4];
        sticky = |mag[3:0];
        inc    = guard & (sticky | mant[0]);
        // A carry out of the mantissa leaves sum[9:0] at zero and bumps the exponent.
        sum    = {1'b0, mant} + (MANT_W+1)'(inc);
        exp    = EXP_TOP - {1'b0, s} + {{(EXP_W-1){1'b0}}, sum[MANT_W]};
        result = (mag == '0) ? HALF_ZERO : {sign, exp, sum[MANT_W-1:0]};
    end

endmodule

// File: rtl/i2f_convert.sv
// i2f_convert: reads a 16-bit integer from data memory, converts it to half float, writes it back
//   clk, reset (async, active-high), start (level request)
//   mem_addr / mem_rd_data / mem_wr_en / mem_wr_data : data-memory port
//   done : result written and valid in memory, held until start drops
import fp16_pkg::*;

module i2f_convert #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] SRC_ADDR = 8'd128,
    parameter logic [ADDR_W-1:0] DST_ADDR = 8'd130
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data,
    output logic              done
);

    i2f_state_t  state, state_nxt;
    logic [7:0]  int_hi;
    logic [15:0] mag;
    logic        sign;
    logic [3:0]  s;
    logic [15:0] result;
    logic [15:0] rnd_result;
    logic        norm_done;

    assign norm_done = (mag == '0) | mag[15];

    fp16_round_rne u_round (
        .mag    (mag),
        .s      (s),
        .sign   (sign),
        .result (rnd_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RD_HI : IDLE;
            RD_HI:   state_nxt = RD_LO;
            RD_LO:   state_nxt = NORM;
            NORM:    state_nxt = norm_done ? ROUND : NORM;
            ROUND:   state_nxt = WR_HI;
            WR_HI:   state_nxt = WR_LO;
            WR_LO:   state_nxt = DONE;
            DONE:    state_nxt = start ? DONE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_addr    = (state == RD_HI) ? SRC_ADDR :
                      (state == RD_LO) ? SRC_ADDR + ADDR_W'(1) :
                      (state == WR_HI) ? DST_ADDR :
                      (state == WR_LO) ? DST_ADDR + ADDR_W'(1) : '0;
        mem_wr_en   = (state == WR_HI) | (state == WR_LO);
        mem_wr_data = (state == WR_HI) ? result[15:8] :
                      (state == WR_LO) ? result[7:0] : '0;
        done        = (state == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_hi <= '0;
            mag    <= '0;
            sign   <= 1'b0;
            s      <= '0;
            result <= '0;
        end else begin
            case (state)
                RD_HI: int_hi <= mem_rd_data;
                RD_LO: begin
                    // Negating 0x8000 wraps back to 0x8000, which is the correct magnitude.
                    sign <= int_hi[7];
                    mag  <= int_hi[7] ? -{int_hi, mem_rd_data} : {int_hi, mem_rd_data};
                    s    <= '0;
                end
                NORM: begin
                    if (!norm_done) begin
                        mag <= mag << 1;
                        s   <= s + 4'd1;
                    end
                end
                ROUND: result <= rnd_result;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/i2f_convert.md
Name: i2f_convert

Overview:
- Hardware int-to-float converter; the upstream producer for the float-to-int stage.
- Reads a 16-bit two's-complement integer (two bytes) from data memory.
- Converts it to IEEE-754 half precision (1/5/10, bias 15) with round-to-nearest-even.
- Writes the result back as two bytes and raises done; its output operand is the float-to-int stage's input.

Parameters:
- SRC_ADDR, 8'd128, address of integer MSB; LSB at SRC_ADDR+1
- DST_ADDR, 8'd130, address of result MSB; LSB at DST_ADDR+1
- ADDR_W, 8, data-memory address width

Ports:
- clk, in, 1, system clock; rising-edge
- reset, in, 1, asynchronous, active-high; 1 = reset, 0 = run
- start, in, 1, level request; sampled in IDLE
- mem_addr, out, ADDR_W, data-memory address (read and write)
- mem_rd_data, in, 8, combinational read data for mem_addr
- mem_wr_en, out, 1, write strobe; memory writes at clk edge
- mem_wr_data, out, 8, write data
- done, out, 1, result written and valid in memory

Behaviour:
- Reset (async) values: state=IDLE, mem_addr=0, mem_wr_en=0, mem_wr_data=0, done=0, internal registers 0.
- mem_wr_en deasserts immediately on reset; a partially written result is left as-is.
- States and transitions:
  - IDLE: start=1 -> RD_HI.
  - RD_HI: addr=SRC_ADDR; latch int[15:8] -> RD_LO.
  - RD_LO: addr=SRC_ADDR+1; latch int[7:0]; form sign=int[15] and 16-bit unsigned mag=|int| (0x8000 stays 0x8000) -> NORM.
  - NORM: if mag==0 or mag[15]=1 -> ROUND; else mag<<=1 and shift count s++ (one bit per cycle, s<=15).
  - ROUND: mant=mag[14:5], guard=mag[4], sticky=|mag[3:0]; increment mant when guard & (sticky | mant[0]); biased exp=30-s; on mantissa carry, mant=0 and exp+1 -> WR_HI.
  - WR_HI: addr=DST_ADDR, wr_en=1, data=result[15:8] -> WR_LO.
  - WR_LO: addr=DST_ADDR+1, wr_en=1, data=result[7:0] -> DONE.
  - DONE: done=1, held while start=1; start=0 -> IDLE with done cleared.
- Zero input: result is 0x0000 (no exp computation). Negative zero cannot occur.
- Range: the largest result is 0x7800 / 0xF800 (±32768); infinity/NaN are never produced.
- Latency: done registered high 6+s clocks after the edge that samples start (s=0 for 0x8000 and for zero; s=15 for ±1). mem_wr_en is high for exactly 2 cycles per conversion.
- start while not in IDLE is ignored. start held high through DONE does not retrigger; it must drop first.
- Output registers mem_addr, mem_wr_en and mem_wr_data are driven from state registers (Moore); no combinational path from mem_rd_data to outputs.

Decomposition:
- Package fp16_pkg holds:
  - EXP_BIAS=15
  - field widths: SIGN_W=1, EXP_W=5, MANT_W=10
  - state enum i2f_state_t {IDLE, RD_HI, RD_LO, NORM, ROUND, WR_HI, WR_LO, DONE}
  - HALF_ZERO=16'h0000
  - the float-to-int stage reuses the package.
- One combinational sub-module, fp16_round_rne: normalized mag[15:0], s, sign -> packed 16-bit result. Kept separately testable.

Test Plan:
- int 0x0001 -> mem[130]=0x3C, mem[131]=0x00; done 21 clocks after start sampled.
- int 0xFFFF (-1) -> 0xBC00.
- int 0x0000 -> 0x0000, done at 6 clocks.
- int 0x8000 -> 0xF800, done at 6 clocks.
- Rounding cases:
  - 0x7FFF -> 0x7800 (carry into exponent).
  - 0x0801 (2049) -> 0x6800 (tie to even, no round).
  - 0x0803 (2051) -> 0x6802 (tie, round up).
- Control cases:
  - Assert reset in NORM of 0x0001 -> outputs 0 at once, no writes, dst bytes unchanged.
  - Release reset, start again -> correct 0x3C00.
  - start held through DONE -> exactly one pair of writes.
